rsa_operand_loader: RTL and testbench

Sequences operand entry for the RSA core. It consumes the byte stream from `uart_rx` as ASCII hex digits and assembles three WIDTH-bit operands in order: message M, exponent E, modulus N. When all three are complete it pulses `core_start` and holds the operands stable until the core reports `core_done`. It sits between `uart_rx` and the RSA datapath and replaces ad-hoc per-digit capture logic with one controller.

---
 rtl/rsa_loader_pkg.sv | 28 ++
 rtl/hex_ascii_decode.sv | 27 ++
 rtl/rsa_operand_loader.sv | 137 +++++++++++++
 tb/tb_rsa_operand_loader.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rsa_loader_pkg.sv
// Shared types and constants for the RSA operand loader and its ASCII decoder.
package rsa_loader_pkg;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_UC_R  = 8'h52;
  localparam logic [7:0] ASCII_LC_R  = 8'h72;

  localparam logic [1:0] OP_M = 2'd0;
  localparam logic [1:0] OP_E = 2'd1;
  localparam logic [1:0] OP_N = 2'd2;

  // Classification of one received byte.
  typedef struct packed {
    logic       is_hex;
    logic       is_ws;
    logic       is_abort;
    logic [3:0] nibble;
  } hex_class_t;

endpackage

// File: rtl/hex_ascii_decode.sv
// Combinational ASCII byte classifier: hex digit value, whitespace, abort key.
module hex_ascii_decode
  import rsa_loader_pkg::*;
(
  input  logic [7:0] data_i,
  output hex_class_t class_c
);

  always_comb begin
    class_c = '0;
    if (data_i >= 8'h30 && data_i <= 8'h39) begin
      class_c.is_hex = 1'b1;
      class_c.nibble = 4'(data_i - 8'h30);
    end else if (data_i >= 8'h41 && data_i <= 8'h46) begin
      class_c.is_hex = 1'b1;
      class_c.nibble = 4'(data_i - 8'h37);
    end else if (data_i >= 8'h61 && data_i <= 8'h66) begin
      class_c.is_hex = 1'b1;
      class_c.nibble = 4'(data_i - 8'h57);
    end else if (data_i == ASCII_SPACE || data_i == ASCII_CR || data_i == ASCII_LF) begin
      class_c.is_ws = 1'b1;
    end else if (data_i == ASCII_UC_R || data_i == ASCII_LC_R) begin
      class_c.is_abort = 1'b1;
    end
  end

endmodule

// File: rtl/rsa_operand_loader.sv
// Assembles M, E, N from an ASCII hex byte stream and hands them to the RSA core.
module rsa_operand_loader
  import rsa_loader_pkg::*;
#(
  parameter  int unsigned WIDTH  = 32,
  localparam int unsigned DIGITS = WIDTH / 4,
  localparam int unsigned CNT_W  = $clog2(DIGITS + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  input  logic             rx_break,
  input  logic             core_done,
  output logic [WIDTH-1:0] op_m,
  output logic [WIDTH-1:0] op_e,
  output logic [WIDTH-1:0] op_n,
  output logic             core_start,
  output logic             busy,
  output logic             err,
  output logic [1:0]       op_idx,
  output logic [CNT_W-1:0] digit_cnt
);

  hex_class_t cls_c;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] op_m_q, op_m_d, op_e_q, op_e_d, op_n_q, op_n_d;
  logic [WIDTH-1:0] sel_op, shifted;
  logic             core_start_q, core_start_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic [1:0]       op_idx_q, op_idx_d;
  logic [CNT_W-1:0] digit_cnt_q, digit_cnt_d;

  hex_ascii_decode u_dec (
    .data_i  (rx_data),
    .class_c (cls_c)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= ST_LOAD;
      op_m_q       <= '0;
      op_e_q       <= '0;
      op_n_q       <= '0;
      core_start_q <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      op_idx_q     <= OP_M;
      digit_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      op_m_q       <= op_m_d;
      op_e_q       <= op_e_d;
      op_n_q       <= op_n_d;
      core_start_q <= core_start_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
      op_idx_q     <= op_idx_d;
      digit_cnt_q  <= digit_cnt_d;
    end
  end

  always_comb begin
    case (op_idx_q)
      OP_M:    sel_op = op_m_q;
      OP_E:    sel_op = op_e_q;
      default: sel_op = op_n_q;
    endcase
    shifted = {sel_op[WIDTH-5:0], cls_c.nibble};
  end

  always_comb begin
    state_d     = state_q;
    op_m_d      = op_m_q;
    op_e_d      = op_e_q;
    op_n_d      = op_n_q;
    err_d       = err_q;
    op_idx_d    = op_idx_q;
    digit_cnt_d = digit_cnt_q;

    case (state_q)
      ST_LOAD: begin
        // Abort wipes the partial entry; an illegal byte also flags err.
        if (rx_break || (rx_valid && !cls_c.is_hex && !cls_c.is_ws)) begin
          if (!rx_break && !cls_c.is_abort) err_d = 1'b1;
          op_m_d      = '0;
          op_e_d      = '0;
          op_n_d      = '0;
          op_idx_d    = OP_M;
          digit_cnt_d = '0;
        end else if (rx_valid && cls_c.is_hex) begin
          if (op_idx_q == OP_M && digit_cnt_q == '0) err_d = 1'b0;
          case (op_idx_q)
            OP_M:    op_m_d = shifted;
            OP_E:    op_e_d = shifted;
            default: op_n_d = shifted;
          endcase
          if (digit_cnt_q == CNT_W'(DIGITS - 1)) begin
            digit_cnt_d = '0;
            if (op_idx_q == OP_N) state_d = ST_START;
            else                  op_idx_d = op_idx_q + 2'd1;
          end else begin
            digit_cnt_d = digit_cnt_q + CNT_W'(1);
          end
        end
      end
      ST_START: begin
        if (rx_valid) err_d = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (rx_valid) err_d = 1'b1;
        if (core_done) begin
          state_d     = ST_LOAD;
          op_idx_d    = OP_M;
          digit_cnt_d = '0;
        end
      end
      default: state_d = ST_LOAD;
    endcase

    core_start_d = (state_d == ST_START);
    busy_d       = (state_d != ST_LOAD);
  end

  assign op_m       = op_m_q;
  assign op_e       = op_e_q;
  assign op_n       = op_n_q;
  assign core_start = core_start_q;
  assign busy       = busy_q;
  assign err        = err_q;
  assign op_idx     = op_idx_q;
  assign digit_cnt  = digit_cnt_q;

endmodule

// File: tb/tb_rsa_operand_loader.sv
// Randomized and directed bench for rsa_operand_loader against a per-byte reference model.
module tb_rsa_operand_loader;

  localparam int DIGITS = 8;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_break = 1'b0;
  logic        core_done = 1'b0;
  logic [31:0] op_m, op_e, op_n;
  logic        core_start, busy, err;
  logic [1:0]  op_idx;
  logic [3:0]  digit_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int n_start  = 0;

  // Reference model: operands as integers, position as (index, count), phase 0/1/2 = loading/start/waiting.
  int unsigned m_op[3];
  int          m_idx, m_cnt, m_phase;
  bit          m_err;

  rsa_operand_loader dut (
    .clk        (clk),
    .resetn     (resetn),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_break   (rx_break),
    .core_done  (core_done),
    .op_m       (op_m),
    .op_e       (op_e),
    .op_n       (op_n),
    .core_start (core_start),
    .busy       (busy),
    .err        (err),
    .op_idx     (op_idx),
    .digit_cnt  (digit_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (core_start === 1'b1) n_start++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int hex_val(input logic [7:0] b);
    if (b >= 8'h30 && b <= 8'h39) return int'(b) - 48;
    if (b >= 8'h41 && b <= 8'h46) return int'(b) - 55;
    if (b >= 8'h61 && b <= 8'h66) return int'(b) - 87;
    return -1;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 3; i++) m_op[i] = 0;
    m_idx = 0;
    m_cnt = 0;
  endtask

  task automatic model_reset();
    model_clear();
    m_err   = 0;
    m_phase = 0;
  endtask

  task automatic model_step(input bit valid, input logic [7:0] b, input bit brk, input bit done);
    int v;
    bit ws;
    case (m_phase)
      0: begin
        v  = hex_val(b);
        ws = (b == 8'h20 || b == 8'h0D || b == 8'h0A);
        if (brk) model_clear();
        else if (valid) begin
          if (v >= 0) begin
            if (m_idx == 0 && m_cnt == 0) m_err = 0;
            m_op[m_idx] = m_op[m_idx] * 16 + v;
            m_cnt++;
            if (m_cnt == DIGITS) begin
              m_cnt = 0;
              if (m_idx == 2) m_phase = 1;
              else            m_idx++;
            end
          end else if (!ws) begin
            if (b != 8'h52 && b != 8'h72) m_err = 1;
            model_clear();
          end
        end
      end
      1: begin
        if (valid) m_err = 1;
        m_phase = 2;
      end
      default: begin
        if (valid) m_err = 1;
        if (done) begin
          m_phase = 0;
          m_idx   = 0;
          m_cnt   = 0;
        end
      end
    endcase
  endtask

  task automatic check_all();
    chk("op_m", op_m, m_op[0]);
    chk("op_e", op_e, m_op[1]);
    chk("op_n", op_n, m_op[2]);
    chk("core_start", 32'(core_start), 32'(m_phase == 1));
    chk("busy", 32'(busy), 32'(m_phase != 0));
    chk("err", 32'(err), 32'(m_err));
    chk("digit_cnt", 32'(digit_cnt), 32'(m_cnt));
    if (m_phase == 0) chk("op_idx", 32'(op_idx), 32'(m_idx));
  endtask

  task automatic tick(input bit valid, input logic [7:0] b, input bit brk, input bit done);
    rx_valid  = valid;
    rx_data   = b;
    rx_break  = brk;
    core_done = done;
    @(posedge clk);
    #1;
    rx_valid  = 1'b0;
    rx_break  = 1'b0;
    core_done = 1'b0;
    model_step(valid, b, brk, done);
    check_all();
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    model_reset();
    check_all();
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) tick(1'b1, s[i], 1'b0, 1'b0);
  endtask

  string hexchars = "0123456789abcdefABCDEF";

  initial begin
    int s0;
    logic [7:0] b;
    int k;

    model_reset();
    do_reset();
    do_reset();
    chk("rst_op_m", op_m, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);

    // Full load with spaces; one start pulse, then WAIT.
    s0 = n_start;
    send_str("0000002A 00000011 00000CA1");
    chk("load_op_m", op_m, 32'h0000002A);
    chk("load_op_e", op_e, 32'h00000011);
    chk("load_op_n", op_n, 32'h00000CA1);
    chk("load_start_now", 32'(core_start), 32'h1);
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    chk("load_one_pulse", 32'(n_start - s0), 32'h1);
    chk("load_busy_wait", 32'(busy), 32'h1);

    // Overrun during WAIT, break ignored, then handback.
    tick(1'b1, 8'h35, 1'b0, 1'b0);
    chk("wait_err", 32'(err), 32'h1);
    chk("wait_op_m_kept", op_m, 32'h0000002A);
    tick(1'b0, 8'h00, 1'b1, 1'b0);
    chk("wait_break_busy", 32'(busy), 32'h1);
    tick(1'b0, 8'h00, 1'b0, 1'b1);
    chk("done_busy_low", 32'(busy), 32'h0);
    send_str("deadBEEF");
    chk("mixed_op_m", op_m, 32'hDEADBEEF);
    chk("mixed_idx", 32'(op_idx), 32'h1);
    chk("mixed_cnt", 32'(digit_cnt), 32'h0);
    chk("mixed_err_clr", 32'(err), 32'h0);

    // Illegal byte and recovery.
    send_str("123G");
    chk("illegal_err", 32'(err), 32'h1);
    chk("illegal_idx", 32'(op_idx), 32'h0);
    chk("illegal_op_m", op_m, 32'h0);
    send_str("1");
    chk("recover_err", 32'(err), 32'h0);
    chk("recover_op_m", op_m, 32'h1);

    // Break and 'r' mid-N.
    do_reset();
    s0 = n_start;
    send_str("1111111122222222333");
    tick(1'b0, 8'h00, 1'b1, 1'b0);
    chk("break_op_n", op_n, 32'h0);
    chk("break_op_m", op_m, 32'h0);
    send_str("44444444555555556666r");
    chk("r_op_e", op_e, 32'h0);
    chk("r_err", 32'(err), 32'h0);
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    chk("abort_no_start", 32'(n_start - s0), 32'h0);

    // Reset during START, then back-to-back digits.
    send_str("AAAAAAAABBBBBBBBCCCCCCCC");
    chk("pre_rst_start", 32'(core_start), 32'h1);
    do_reset();
    chk("rst_start_op_n", op_n, 32'h0);
    chk("rst_start_busy", 32'(busy), 32'h0);
    send_str("12345678");
    chk("b2b_op_m", op_m, 32'h12345678);

    // Reset during WAIT.
    send_str("9999999988888888");
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    do_reset();
    chk("rst_wait_err", 32'(err), 32'h0);

    // Randomized traffic.
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        k = $urandom_range(0, 99);
        if (k < 80)      b = hexchars[$urandom_range(0, 21)];
        else if (k < 92) begin
          case ($urandom_range(0, 2))
            0:       b = 8'h20;
            1:       b = 8'h0D;
            default: b = 8'h0A;
          endcase
        end
        else if (k < 94) b = ($urandom_range(0, 1) == 0) ? 8'h52 : 8'h72;
        else if (k < 96) b = 8'($urandom_range(0, 255));
        else             b = hexchars[$urandom_range(0, 9)];
        tick($urandom_range(0, 9) < 8, b, $urandom_range(0, 299) == 0,
             $urandom_range(0, 3) == 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
